f2m_sqrt: RTL and testbench

- Iterative square root over F_{2^m}: z = sqrt(a) mod f(x), computed as a^(2^(M-1)) by repeated modular squaring.
- Inverse of the combinational squarer. Used by point decompression and half-trace paths in the binary-field EC datapath.
- Start/done handshake; the result is held in a register until the next operation completes.

---
 rtl/f2m_sqrt.sv | 107 ++++++++++
 tb/tb_f2m_sqrt.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/f2m_sqrt.sv
// Square root in GF(2^M) by repeated squaring: z = a^(2^(M-1)) mod f(x).
// States: S_IDLE | waiting for start ; S_RUN | applying K squarings per clock
module f2m_sqrt #(
  parameter int          M  = 163,
  parameter logic [M-1:0] FX = 163'hc9,
  parameter int          K  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] z
);

  localparam int N  = (M - 1) / K;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] TC = CW'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [M-1:0]   r_acc, w_acc_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic [M-1:0]   r_z, w_z_nxt;
  logic [M-1:0]   w_sqk;

  // Squaring is linear: spread bits to even positions, then fold every
  // x^j (j >= M) back as x^(j-M) * FX, highest term first.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] v);
    logic [2*M-2:0] e;
    e = '0;
    for (int i = 0; i < M; i++) e[2*i] = v[i];
    for (int j = 2*M-2; j >= M; j--) begin
      if (e[j]) e[j-M +: M] = e[j-M +: M] ^ FX;
    end
    return e[M-1:0];
  endfunction

  function automatic logic [M-1:0] gf_sqk(input logic [M-1:0] v);
    logic [M-1:0] t;
    t = v;
    for (int k = 0; k < K; k++) t = gf_sq(t);
    return t;
  endfunction

  assign w_sqk = gf_sqk(r_acc);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_z_nxt     = r_z;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_nxt   = a;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_acc_nxt = w_sqk;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == TC) begin
          w_z_nxt     = w_sqk;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_z     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_z     <= w_z_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign z    = r_z;

endmodule

// File: tb/tb_f2m_sqrt.sv
// Bench for f2m_sqrt: three instances (K=1,2,3) checked against a
// shift-and-add GF(2^163) multiply model.
module tb_f2m_sqrt;
  localparam int M = 163;
  localparam logic [M-1:0] FX = 163'hc9;

  logic clk = 1'b0;
  logic rst_n;
  logic         start_s [3];
  logic [M-1:0] a_s     [3];
  logic         busy_s  [3];
  logic         done_s  [3];
  logic [M-1:0] z_s     [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    f2m_sqrt #(.M(M), .FX(FX), .K(g + 1)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start_s[g]),
      .a    (a_s[g]),
      .busy (busy_s[g]),
      .done (done_s[g]),
      .z    (z_s[g])
    );
  end

  // Reference arithmetic: schoolbook multiply with interleaved reduction.
  function automatic logic [M-1:0] gmul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] acc;
    logic top;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      top = acc[M-1];
      acc = acc << 1;
      if (top) acc = acc ^ FX;
      if (y[i]) acc = acc ^ x;
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] gsqrt(input logic [M-1:0] x);
    logic [M-1:0] t;
    t = x;
    for (int i = 0; i < M - 1; i++) t = gmul(t, t);
    return t;
  endfunction

  function automatic logic [M-1:0] rand163();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[M-1:0];
  endfunction

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input int g, input logic [M-1:0] av, output logic [M-1:0] zo, output int lat);
    int n;
    @(negedge clk);
    a_s[g] = av;
    start_s[g] = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_accept", {162'd0, busy_s[g]}, 1);
    @(negedge clk);
    start_s[g] = 1'b0;
    a_s[g] = rand163();
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (done_s[g]) break;
    end
    zo  = z_s[g];
    lat = n;
    chk("busy_in_done_cycle", {162'd0, busy_s[g]}, 0);
    @(posedge clk);
    #1;
    chk("done_single_pulse", {162'd0, done_s[g]}, 0);
    chk("z_held", z_s[g], zo);
  endtask

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] z;
  } vec_t;

  vec_t tv [6];

  initial begin
    logic [M-1:0] zr, a0, a1;
    int lat, n, cnt;

    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M-1:0] zr, a0, a1, av;
    int lat, n, cnt;

    tv[0].a = 163'd0;            tv[0].z = 163'd0;
    tv[1].a = 163'd1;            tv[1].z = 163'd1;
    tv[2].a = 163'h4;            tv[2].z = 163'h2;
    tv[3].a = 163'h10;           tv[3].z = 163'h4;
    tv[4].a = 163'd1 << 162;     tv[4].z = 163'd1 << 81;
    tv[5].a = 163'h2;            tv[5].z = gsqrt(163'h2);

    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start_s[g] = 1'b0;
      a_s[g] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        chk("idle_busy", {162'd0, busy_s[g]}, 0);
        chk("idle_done", {162'd0, done_s[g]}, 0);
        chk("idle_z", z_s[g], 0);
      end
    end

    for (int i = 0; i < 6; i++) begin
      run_op(0, tv[i].a, zr, lat);
      chk("table_z", zr, tv[i].z);
      chk("table_z_squared", gmul(zr, zr), tv[i].a);
      chk("table_latency", M'(lat), 162);
    end

    for (int g = 0; g < 3; g++) begin
      cnt = (g == 0) ? 60 : ((g == 1) ? 150 : 200);
      for (int i = 0; i < cnt; i++) begin
        av = rand163();
        run_op(g, av, zr, lat);
        chk("rand_z_model", zr, gsqrt(av));
        chk("rand_z_squared", gmul(zr, zr), av);
        chk("rand_latency", M'(lat), M'(162 / (g + 1)));
      end
    end

    // start held high with a churning operand, then back-to-back accept in done cycle
    a0 = rand163();
    @(negedge clk);
    a_s[0] = a0;
    start_s[0] = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      a_s[0] = rand163();
      @(posedge clk);
      n++;
      #1;
      if (done_s[0]) break;
    end
    chk("held_latency", M'(n), 162);
    chk("held_z", z_s[0], gsqrt(a0));
    a1 = rand163();
    @(negedge clk);
    a_s[0] = a1;
    @(posedge clk);
    #1;
    chk("b2b_done_cleared", {162'd0, done_s[0]}, 0);
    chk("b2b_busy", {162'd0, busy_s[0]}, 1);
    chk("b2b_z_kept", z_s[0], gsqrt(a0));
    @(negedge clk);
    start_s[0] = 1'b0;
    a_s[0] = rand163();
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (done_s[0]) break;
    end
    chk("b2b_latency", M'(n), 162);
    chk("b2b_z", z_s[0], gsqrt(a1));

    // asynchronous reset in the middle of a run
    @(negedge clk);
    a_s[0] = rand163();
    start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (80) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {162'd0, busy_s[0]}, 0);
    chk("rst_done", {162'd0, done_s[0]}, 0);
    chk("rst_z", z_s[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    av = rand163();
    run_op(0, av, zr, lat);
    chk("post_rst_z", zr, gsqrt(av));
    chk("post_rst_latency", M'(lat), 162);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
